// File: rtl/elevator_scheduler_if.sv
// Call/floor bundle between the button logic, the elevator core and elevator_scheduler.
// serviced_count is present only when ELEVATOR_SCHED_STATS_EN is defined.
interface elevator_scheduler_if #(
    parameter int FLOORS = 16
);
    logic              call_valid;
    logic [3:0]        call_floor;
    logic [3:0]        currentFloor;
    logic [3:0]        requestFloor;
    logic              door_open;
    logic              dir_up;
    logic              busy;
    logic [FLOORS-1:0] pending;
`ifdef ELEVATOR_SCHED_STATS_EN
    logic [15:0]       serviced_count;
`endif

    modport master (
        output call_valid, call_floor, currentFloor,
`ifdef ELEVATOR_SCHED_STATS_EN
        input  serviced_count,
`endif
        input  requestFloor, door_open, dir_up, busy, pending
    );

    modport slave (
        input  call_valid, call_floor, currentFloor,
`ifdef ELEVATOR_SCHED_STATS_EN
        output serviced_count,
`endif
        output requestFloor, door_open, dir_up, busy, pending
    );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN floor-call scheduler with door dwell; optional stop counter via ELEVATOR_SCHED_STATS_EN.
module elevator_scheduler #(
    parameter int FLOORS      = 16,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] ONE        = FLOORS'(1);

    state_t            state;
    logic [FLOORS-1:0] pending_q;
    logic [3:0]        request_q;
    logic              door_q;
    logic              dir_q;
    logic [CNT_W-1:0]  dwell;

    logic              call_ok;
    logic [FLOORS-1:0] call_mask;
    logic [FLOORS-1:0] here_mask;
    logic              here;
    logic              above_vld;
    logic              below_vld;
    logic [3:0]        above;
    logic [3:0]        below;
    logic              up_first;
    logic              enter_door;

    // Nearest pending floor at/above and at/below the car, from the registered mask.
    always_comb begin
        call_ok   = bus.call_valid && (int'(bus.call_floor) < FLOORS);
        call_mask = call_ok ? (ONE << bus.call_floor) : '0;
        here_mask = ONE << bus.currentFloor;
        here      = |(pending_q & here_mask);
        above_vld = 1'b0;
        above     = '0;
        below_vld = 1'b0;
        below     = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && i >= int'(bus.currentFloor)) begin
                above_vld = 1'b1;
                above     = 4'(i);
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && i <= int'(bus.currentFloor)) begin
                below_vld = 1'b1;
                below     = 4'(i);
            end
        end
        up_first   = above_vld &&
                     (!below_vld || ((above - bus.currentFloor) <= (bus.currentFloor - below)));
        enter_door = (state != DOOR) && here;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending_q <= '0;
            request_q <= '0;
            door_q    <= 1'b0;
            dir_q     <= 1'b1;
            dwell     <= '0;
        end else if (enter_door) begin
            // Arrival wins over a same-edge call to this floor: the bit stays clear.
            state     <= DOOR;
            door_q    <= 1'b1;
            dwell     <= DWELL_LOAD;
            request_q <= bus.currentFloor;
            pending_q <= (pending_q | call_mask) & ~here_mask;
        end else begin
            pending_q <= pending_q | call_mask;
            case (state)
                IDLE: begin
                    request_q <= bus.currentFloor;
                    if (up_first) begin
                        dir_q     <= 1'b1;
                        state     <= MOVE_UP;
                        request_q <= above;
                    end else if (below_vld) begin
                        dir_q     <= 1'b0;
                        state     <= MOVE_DOWN;
                        request_q <= below;
                    end
                end
                MOVE_UP: begin
                    if (above_vld) begin
                        request_q <= above;
                    end else if (below_vld) begin
                        dir_q     <= 1'b0;
                        state     <= MOVE_DOWN;
                        request_q <= below;
                    end else begin
                        state     <= IDLE;
                        request_q <= bus.currentFloor;
                    end
                end
                MOVE_DOWN: begin
                    if (below_vld) begin
                        request_q <= below;
                    end else if (above_vld) begin
                        dir_q     <= 1'b1;
                        state     <= MOVE_UP;
                        request_q <= above;
                    end else begin
                        state     <= IDLE;
                        request_q <= bus.currentFloor;
                    end
                end
                DOOR: begin
                    // A re-call to the open floor is swallowed and restarts the dwell.
                    request_q <= bus.currentFloor;
                    pending_q <= pending_q | (call_mask & ~here_mask);
                    if (call_ok && (call_mask == here_mask)) begin
                        dwell <= DWELL_LOAD;
                    end else if (dwell == '0) begin
                        door_q <= 1'b0;
                        if (pending_q != '0) begin
                            state <= dir_q ? MOVE_UP : MOVE_DOWN;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dwell <= dwell - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ELEVATOR_SCHED_STATS_EN
    logic [15:0] serviced_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            serviced_q <= '0;
        end else if (enter_door && (serviced_q != 16'hFFFF)) begin
            serviced_q <= serviced_q + 16'd1;
        end
    end

    assign bus.serviced_count = serviced_q;
`endif

    assign bus.requestFloor = request_q;
    assign bus.door_open    = door_q;
    assign bus.dir_up       = dir_q;
    assign bus.busy         = (state != IDLE) || (|pending_q);
    assign bus.pending      = pending_q;

endmodule
